// File: rtl/mac_output_drain.sv
// Ping-pong output drain for the 16-lane MAC array.
// Captures 16 lane results at once and streams them one channel per beat on a valid/ready bus.
module mac_output_drain #(
  parameter int OUTPUT_WIDTH = 16,
  parameter bit RELU_EN      = 1'b0
) (
  input  logic                           clk,
  input  logic                           arst_n_in,
  input  logic                           capture,
  input  logic signed [OUTPUT_WIDTH-1:0] in0,
  input  logic signed [OUTPUT_WIDTH-1:0] in1,
  input  logic signed [OUTPUT_WIDTH-1:0] in2,
  input  logic signed [OUTPUT_WIDTH-1:0] in3,
  input  logic signed [OUTPUT_WIDTH-1:0] in4,
  input  logic signed [OUTPUT_WIDTH-1:0] in5,
  input  logic signed [OUTPUT_WIDTH-1:0] in6,
  input  logic signed [OUTPUT_WIDTH-1:0] in7,
  input  logic signed [OUTPUT_WIDTH-1:0] in8,
  input  logic signed [OUTPUT_WIDTH-1:0] in9,
  input  logic signed [OUTPUT_WIDTH-1:0] in10,
  input  logic signed [OUTPUT_WIDTH-1:0] in11,
  input  logic signed [OUTPUT_WIDTH-1:0] in12,
  input  logic signed [OUTPUT_WIDTH-1:0] in13,
  input  logic signed [OUTPUT_WIDTH-1:0] in14,
  input  logic signed [OUTPUT_WIDTH-1:0] in15,
  output logic                           capture_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic [3:0]                     out_ch,
  output logic                           out_last,
  output logic                           overflow,
  input  logic                           clear_overflow
);

  logic signed [OUTPUT_WIDTH-1:0] lane_in  [16];
  logic signed [OUTPUT_WIDTH-1:0] lane_val [16];
  logic signed [OUTPUT_WIDTH-1:0] bank     [2][16];
  logic [1:0] full;
  logic       wr_bank;
  logic       rd_bank;
  logic [3:0] ch;
  logic       cap_ok;
  logic       beat;

  always_comb begin
    lane_in[0]  = in0;  lane_in[1]  = in1;  lane_in[2]  = in2;  lane_in[3]  = in3;
    lane_in[4]  = in4;  lane_in[5]  = in5;  lane_in[6]  = in6;  lane_in[7]  = in7;
    lane_in[8]  = in8;  lane_in[9]  = in9;  lane_in[10] = in10; lane_in[11] = in11;
    lane_in[12] = in12; lane_in[13] = in13; lane_in[14] = in14; lane_in[15] = in15;
  end

  // ReLU on the sign bit alone, so the most-negative value also clamps to 0
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      lane_val[k] = (RELU_EN && lane_in[k][OUTPUT_WIDTH-1]) ? '0 : lane_in[k];
    end
  end

  assign capture_ready = !full[wr_bank];
  assign out_valid     = full[rd_bank];
  assign out_data      = bank[rd_bank][ch];
  assign out_ch        = ch;
  assign out_last      = out_valid && (ch == 4'd15);
  assign cap_ok        = capture && capture_ready;
  assign beat          = out_valid && out_ready;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 16; k++) begin
          bank[b][k] <= '0;
        end
      end
    end else if (cap_ok) begin
      for (int k = 0; k < 16; k++) begin
        bank[wr_bank][k] <= lane_val[k];
      end
    end
  end

  // cap_ok needs full[wr_bank]==0 and beat needs full[rd_bank]==1, so the two never touch the same bank
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      full     <= 2'b00;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      ch       <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (cap_ok) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (beat) begin
        ch <= ch + 4'd1;
        if (ch == 4'd15) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
      if (capture && !capture_ready) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
